// File: rtl/udp_rx_vid_framer.sv
// UDP payload byte stream to video-timing pixel framer (head/tail markers, H/V geometry, timeout).
// Optional UDP_RX_VID_STAT_EN adds saturating frame_ok_cnt / frame_err_cnt outputs.
module udp_rx_vid_framer #(
  parameter logic [31:0] FRAME_HEAD = 32'hF3ED7A93,
  parameter logic [31:0] FRAME_TAIL = 32'hF3ED7A94,
  parameter int unsigned PIX_BYTES  = 2,
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                   app_rx_clk,
  input  logic                   rst,
  input  logic                   app_rx_data_valid,
  input  logic [7:0]             app_rx_data,
  output logic                   vid_clk,
  output logic                   vid_vs,
  output logic                   vid_de,
  output logic [8*PIX_BYTES-1:0] vid_data,
  output logic                   vid_eol,
  output logic                   vid_eof,
  output logic                   frame_err,
  output logic                   busy
`ifdef UDP_RX_VID_STAT_EN
  ,
  output logic [15:0]            frame_ok_cnt,
  output logic [15:0]            frame_err_cnt
`endif
);

  localparam int unsigned PW    = 8 * PIX_BYTES;
  localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned IW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, REC} state_t;

  state_t          state_q, state_d;
  logic [23:0]     sr_q, sr_d;
  logic [PW-1:0]   pack_q, pack_d;
  logic [1:0]      byte_q, byte_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   pix_q, pix_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            vs_q, vs_d, de_q, de_d, eol_q, eol_d, eof_q, eof_d, err_q, err_d;
  logic [PW-1:0]   data_q, data_d;

  logic [31:0]     hd_next;
  logic            is_head, is_tail, clr;
  logic [PW-1:0]   pix_w;

  assign hd_next = {sr_q, app_rx_data};
  assign is_head = app_rx_data_valid && (hd_next == FRAME_HEAD);
  assign is_tail = app_rx_data_valid && (hd_next == FRAME_TAIL);
  // Shift-in form keeps PIX_BYTES=1 free of zero-width slices.
  assign pix_w   = (pack_q << 8) | PW'(app_rx_data);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pack_d  = pack_q;
    byte_d  = byte_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    idle_d  = idle_q;
    vs_d    = 1'b0;
    de_d    = 1'b0;
    data_d  = '0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;

    if (app_rx_data_valid) sr_d = (is_head || is_tail) ? '0 : hd_next[23:0];

    case (state_q)
      IDLE: begin
        idle_d = '0;
        if (is_head) begin
          state_d = REC;
          vs_d    = 1'b1;
          clr     = 1'b1;
        end
      end
      REC: begin
        idle_d = app_rx_data_valid ? '0 : idle_q + 1'b1;
        if (is_head) begin
          vs_d  = 1'b1;
          err_d = 1'b1;
          clr   = 1'b1;
        end else if (is_tail) begin
          state_d = IDLE;
          err_d   = (pix_q < CW'(TOTAL));
          clr     = 1'b1;
        end else if (app_rx_data_valid) begin
          if (byte_q == 2'(PIX_BYTES - 1)) begin
            byte_d = '0;
            pack_d = '0;
            de_d   = 1'b1;
            data_d = pix_w;
            eol_d  = (x_q == XW'(H_ACTIVE - 1));
            eof_d  = (pix_q == CW'(TOTAL - 1));
            pix_d  = pix_q + 1'b1;
            if (eol_d) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
            if (eof_d) begin
              state_d = IDLE;
              clr     = 1'b1;
            end
          end else begin
            byte_d = byte_q + 1'b1;
            pack_d = pix_w;
          end
        end else if (idle_q == IW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      pack_d = '0;
      byte_d = '0;
      x_d    = '0;
      y_d    = '0;
      pix_d  = '0;
    end
  end

  always_ff @(posedge app_rx_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pack_q  <= '0;
      byte_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
      idle_q  <= '0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      data_q  <= '0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pack_q  <= pack_d;
      byte_q  <= byte_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      idle_q  <= idle_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      data_q  <= data_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
    end
  end

  assign vid_clk   = app_rx_clk;
  assign vid_vs    = vs_q;
  assign vid_de    = de_q;
  assign vid_data  = data_q;
  assign vid_eol   = eol_q;
  assign vid_eof   = eof_q;
  assign frame_err = err_q;
  assign busy      = (state_q == REC);

`ifdef UDP_RX_VID_STAT_EN
  logic [15:0] ok_cnt_q, err_cnt_q;

  always_ff @(posedge app_rx_clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (eof_q && (ok_cnt_q != '1))  ok_cnt_q  <= ok_cnt_q + 1'b1;
      if (err_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_udp_rx_vid_framer.sv
// Directed scoreboard bench for udp_rx_vid_framer: instance A (2 B/pix, 4x2, TIMEOUT 16), instance B (3 B/pix, 4x2).
module tb_udp_rx_vid_framer;

  typedef struct packed {
    logic [23:0] data;
    logic        eol;
    logic        eof;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        va, vb;
  logic [7:0]  da, db;
  logic        clk_a, vs_a, de_a, eol_a, eof_a, err_a, busy_a;
  logic        clk_b, vs_b, de_b, eol_b, eof_b, err_b, busy_b;
  logic [15:0] data_a;
  logic [23:0] data_b;
`ifdef UDP_RX_VID_STAT_EN
  logic [15:0] okc_a, errc_a, okc_b, errc_b;
`endif

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int vectors = 0;
  int miscompares = 0;
  int pix_a = 0, pix_b = 0, vs_cnt_a = 0, vs_cnt_b = 0, err_cnt_a = 0, err_cnt_b = 0;

  always #5 clk = ~clk;

  udp_rx_vid_framer #(.PIX_BYTES(2), .H_ACTIVE(4), .V_ACTIVE(2), .TIMEOUT(16)) dut_a (
    .app_rx_clk(clk), .rst(rst), .app_rx_data_valid(va), .app_rx_data(da),
    .vid_clk(clk_a), .vid_vs(vs_a), .vid_de(de_a), .vid_data(data_a),
    .vid_eol(eol_a), .vid_eof(eof_a), .frame_err(err_a), .busy(busy_a)
`ifdef UDP_RX_VID_STAT_EN
    , .frame_ok_cnt(okc_a), .frame_err_cnt(errc_a)
`endif
  );

  udp_rx_vid_framer #(.PIX_BYTES(3), .H_ACTIVE(4), .V_ACTIVE(2), .TIMEOUT(64)) dut_b (
    .app_rx_clk(clk), .rst(rst), .app_rx_data_valid(vb), .app_rx_data(db),
    .vid_clk(clk_b), .vid_vs(vs_b), .vid_de(de_b), .vid_data(data_b),
    .vid_eol(eol_b), .vid_eof(eof_b), .frame_err(err_b), .busy(busy_b)
`ifdef UDP_RX_VID_STAT_EN
    , .frame_ok_cnt(okc_b), .frame_err_cnt(errc_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    @(negedge clk); va = 1'b1; da = b;
  endtask
  task automatic gap_a(input int n);
    repeat (n) begin @(negedge clk); va = 1'b0; end
  endtask
  task automatic word_a(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_a(w[31-8*i -: 8]);
  endtask
  task automatic send_b(input logic [7:0] b);
    @(negedge clk); vb = 1'b1; db = b;
  endtask
  task automatic gap_b(input int n);
    repeat (n) begin @(negedge clk); vb = 1'b0; end
  endtask
  task automatic push_a(input logic [23:0] d, input logic eol, input logic eof);
    qa.push_back('{data: d, eol: eol, eof: eof});
  endtask
  task automatic push_frame_a();
    for (int p = 0; p < 8; p++)
      push_a({8'h00, 8'(2*p), 8'(2*p+1)}, (p % 4) == 3, p == 7);
  endtask

  // Scoreboard monitor: every vid_de pops one expected pixel.
  always @(negedge clk) begin
    if (!rst) begin
      if (de_a) begin
        chk("A_sb_avail", 32'(qa.size() > 0), 32'd1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("A_pix_data", 32'(data_a), 32'(ea.data));
          chk("A_pix_eol", 32'(eol_a), 32'(ea.eol));
          chk("A_pix_eof", 32'(eof_a), 32'(ea.eof));
        end
        pix_a++;
      end else begin
        chk("A_blank", {14'd0, eol_a, eof_a, data_a}, 32'd0);
      end
      if (de_b) begin
        chk("B_sb_avail", 32'(qb.size() > 0), 32'd1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("B_pix_data", 32'(data_b), 32'(eb.data));
          chk("B_pix_eol", 32'(eol_b), 32'(eb.eol));
          chk("B_pix_eof", 32'(eof_b), 32'(eb.eof));
        end
        pix_b++;
      end
      if (vs_a) vs_cnt_a++;
      if (vs_b) vs_cnt_b++;
      if (err_a) err_cnt_a++;
      if (err_b) err_cnt_b++;
    end
  end

  initial begin
    int p0, e0, v0, first_err, npulse, busy16;
    rst = 1'b1; va = 1'b0; da = '0; vb = 1'b0; db = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs_a", {25'd0, vs_a, de_a, eol_a, eof_a, err_a, busy_a, |data_a}, 32'd0);
    chk("rst_outs_b", {25'd0, vs_b, de_b, eol_b, eof_b, err_b, busy_b, |data_b}, 32'd0);
    rst = 1'b0;
    gap_a(2);

    // T1: full frame
    p0 = pix_a; e0 = err_cnt_a; v0 = vs_cnt_a;
    word_a(32'hF3ED7A93);
    gap_a(1);
    chk("T1_vs_latency", 32'(vs_a), 32'd1);
    chk("T1_busy", 32'(busy_a), 32'd1);
    push_frame_a();
    for (int i = 0; i < 16; i++) send_a(8'(i));
    gap_a(4);
    chk("T1_pixels", 32'(pix_a - p0), 32'd8);
    chk("T1_drain", 32'(qa.size()), 32'd0);
    chk("T1_no_err", 32'(err_cnt_a - e0), 32'd0);
    chk("T1_vs_cnt", 32'(vs_cnt_a - v0), 32'd1);
    chk("T1_idle", 32'(busy_a), 32'd0);

    // T2: short frame; tail bytes F3/ED/7A are packed as data ahead of the 94
    p0 = pix_a; e0 = err_cnt_a;
    push_a(24'h0001, 1'b0, 1'b0);
    push_a(24'h0203, 1'b0, 1'b0);
    push_a(24'h04F3, 1'b0, 1'b0);
    push_a(24'hED7A, 1'b1, 1'b0);
    word_a(32'hF3ED7A93);
    for (int i = 0; i < 5; i++) send_a(8'(i));
    word_a(32'hF3ED7A94);
    gap_a(4);
    chk("T2_pixels", 32'(pix_a - p0), 32'd4);
    chk("T2_drain", 32'(qa.size()), 32'd0);
    chk("T2_err", 32'(err_cnt_a - e0), 32'd1);
    chk("T2_idle", 32'(busy_a), 32'd0);

    // T3: head mid-frame resyncs
    p0 = pix_a; e0 = err_cnt_a; v0 = vs_cnt_a;
    push_a(24'h0001, 1'b0, 1'b0);
    push_a(24'h0203, 1'b0, 1'b0);
    push_a(24'h0405, 1'b0, 1'b0);
    push_a(24'hF3ED, 1'b1, 1'b0);
    push_frame_a();
    word_a(32'hF3ED7A93);
    for (int i = 0; i < 6; i++) send_a(8'(i));
    word_a(32'hF3ED7A93);
    for (int i = 0; i < 16; i++) send_a(8'(i));
    gap_a(4);
    chk("T3_pixels", 32'(pix_a - p0), 32'd12);
    chk("T3_drain", 32'(qa.size()), 32'd0);
    chk("T3_err", 32'(err_cnt_a - e0), 32'd1);
    chk("T3_vs_cnt", 32'(vs_cnt_a - v0), 32'd2);
    chk("T3_idle", 32'(busy_a), 32'd0);

    // T4: timeout after 16 idle clocks past the capture of the last byte
    p0 = pix_a; first_err = 0; npulse = 0; busy16 = 0;
    push_a(24'h0001, 1'b0, 1'b0);
    word_a(32'hF3ED7A93);
    send_a(8'h00); send_a(8'h01); send_a(8'h02);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); va = 1'b0;
      if (err_a) begin
        npulse++;
        if (first_err == 0) first_err = k;
      end
      if (k == 16) busy16 = int'(busy_a);
    end
    chk("T4_err_time", 32'(first_err), 32'd17);
    chk("T4_err_pulses", 32'(npulse), 32'd1);
    chk("T4_busy_before", 32'(busy16), 32'd1);
    chk("T4_idle", 32'(busy_a), 32'd0);
    chk("T4_pixels", 32'(pix_a - p0), 32'd1);
    chk("T4_drain", 32'(qa.size()), 32'd0);

    // T5: 3-byte pixels with gaps
    for (int p = 0; p < 8; p++)
      qb.push_back('{data: {8'(3*p), 8'(3*p+1), 8'(3*p+2)}, eol: (p % 4) == 3, eof: p == 7});
    send_b(8'hF3); send_b(8'hED); send_b(8'h7A); send_b(8'h93);
    gap_b(1);
    chk("T5_vs", 32'(vs_b), 32'd1);
    for (int i = 0; i < 24; i++) begin
      send_b(8'(i));
      gap_b((i == 11) ? 10 : 1);
    end
    gap_b(4);
    chk("T5_pixels", 32'(pix_b), 32'd8);
    chk("T5_drain", 32'(qb.size()), 32'd0);
    chk("T5_no_err", 32'(err_cnt_b), 32'd0);
    chk("T5_idle", 32'(busy_b), 32'd0);

    // T6: reset mid-frame, then a clean frame
    e0 = err_cnt_a; p0 = pix_a;
    push_a(24'h0001, 1'b0, 1'b0);
    push_a(24'h0203, 1'b0, 1'b0);
    word_a(32'hF3ED7A93);
    for (int i = 0; i < 5; i++) send_a(8'(i));
    @(negedge clk); va = 1'b0; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("T6_rst_outs", {25'd0, vs_a, de_a, eol_a, eof_a, err_a, busy_a, |data_a}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    gap_a(2);
    push_frame_a();
    word_a(32'hF3ED7A93);
    for (int i = 0; i < 16; i++) send_a(8'(i));
    gap_a(4);
    chk("T6_pixels", 32'(pix_a - p0), 32'd10);
    chk("T6_drain", 32'(qa.size()), 32'd0);
    chk("T6_no_err", 32'(err_cnt_a - e0), 32'd0);
    chk("T6_idle", 32'(busy_a), 32'd0);
`ifdef UDP_RX_VID_STAT_EN
    chk("T6_ok_cnt", 32'(okc_a), 32'd1);
    chk("T6_err_cnt", 32'(errc_a), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
